// File: rtl/common_dffram_fifo_pkg.sv
// Shared sizing helpers and pop-count encoding for the DFF RAM FIFO controllers.
package common_dffram_fifo_pkg;

    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_ONE  = 2'd1,
        POP_TWO  = 2'd2
    } pop_cnt_e;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    function automatic int unsigned fifo_cnt_width(input int unsigned addr_width);
        return addr_width + 32'd1;
    endfunction

endpackage

// File: rtl/common_dffram_3a1we2r.sv
// DFF RAM with one bit-enabled write port (A) and two combinational read ports (B, C).
// Contents are never reset; resetn low only blocks writes.
module common_dffram_3a1we2r #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ena,
    input  logic [DATA_WIDTH-1:0] wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb,
    input  logic [ADDR_WIDTH-1:0] addrc,
    output logic [DATA_WIDTH-1:0] doutc
);
    import common_dffram_fifo_pkg::*;

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Per-bit masked write; reads see pre-edge contents.
    always_ff @(posedge clk) begin
        if (ena && resetn) begin
            mem_q[addra] <= (mem_q[addra] & ~wea) | (dina & wea);
        end
    end

    assign doutb = mem_q[addrb];
    assign doutc = mem_q[addrc];

endmodule

// File: rtl/common_dffram_fifo_1w2r.sv
// In-order FIFO: one push and up to two pops per cycle over a 1W2R DFF RAM.
// Optional same-cycle empty bypass on slot 0: COMMON_DFFRAM_FIFO_1W2R_BYPASS_EN.
module common_dffram_fifo_1w2r #(
    parameter int unsigned FIFO_DATA_WIDTH = 32,
    parameter int unsigned FIFO_ADDR_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [FIFO_DATA_WIDTH-1:0] push_data,
    output logic                       pop0_valid,
    input  logic                       pop0_ready,
    output logic [FIFO_DATA_WIDTH-1:0] pop0_data,
    output logic                       pop1_valid,
    input  logic                       pop1_ready,
    output logic [FIFO_DATA_WIDTH-1:0] pop1_data,
    output logic [FIFO_ADDR_WIDTH:0]   count,
    output logic                       empty,
    output logic                       full
);
    import common_dffram_fifo_pkg::*;

    localparam int unsigned AW    = FIFO_ADDR_WIDTH;
    localparam int unsigned CW    = fifo_cnt_width(FIFO_ADDR_WIDTH);
    localparam int unsigned DEPTH = fifo_depth(FIFO_ADDR_WIDTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;

    logic                       push_fire_c;
    logic                       pop0_fire_c;
    logic                       pop1_fire_c;
    logic                       bypass_take_c;
    logic                       wr_en_c;
    logic                       mem_pop0_c;
    pop_cnt_e                   pop_n_c;
    logic [AW-1:0]              rd_ptr1_c;
    logic [FIFO_DATA_WIDTH-1:0] rd0_data_c;
    logic [FIFO_DATA_WIDTH-1:0] rd1_data_c;

    // Handshake views; push_ready only looks at registered state and flush.
    always_comb begin
        push_ready  = !full_q && !flush;
        pop1_valid  = (count_q >= CW'(2)) && !flush;
`ifdef COMMON_DFFRAM_FIFO_1W2R_BYPASS_EN
        pop0_valid  = (!empty_q || push_valid) && !flush;
        pop0_data   = empty_q ? push_data : rd0_data_c;
`else
        pop0_valid  = !empty_q && !flush;
        pop0_data   = rd0_data_c;
`endif
        pop1_data   = rd1_data_c;
        push_fire_c = push_valid && push_ready;
        pop0_fire_c = pop0_valid && pop0_ready;
        pop1_fire_c = pop1_valid && pop1_ready && pop0_fire_c;
    end

    // Next-state: a bypassed entry neither lands in the RAM nor moves pointers.
    always_comb begin
        bypass_take_c = 1'b0;
`ifdef COMMON_DFFRAM_FIFO_1W2R_BYPASS_EN
        bypass_take_c = empty_q && push_fire_c && pop0_fire_c;
`endif
        wr_en_c    = push_fire_c && !bypass_take_c;
        mem_pop0_c = pop0_fire_c && !bypass_take_c;

        pop_n_c = POP_NONE;
        if (mem_pop0_c && pop1_fire_c) begin
            pop_n_c = POP_TWO;
        end else if (mem_pop0_c) begin
            pop_n_c = POP_ONE;
        end

        wr_ptr_d = wr_ptr_q + AW'(wr_en_c);
        rd_ptr_d = rd_ptr_q + AW'(pop_n_c);
        count_d  = count_q + CW'(wr_en_c) - CW'(pop_n_c);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign rd_ptr1_c = rd_ptr_q + AW'(1);

    common_dffram_3a1we2r #(
        .DATA_WIDTH (FIFO_DATA_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .resetn (1'b1),
        .ena    (wr_en_c),
        .wea    ({FIFO_DATA_WIDTH{1'b1}}),
        .addra  (wr_ptr_q),
        .dina   (push_data),
        .addrb  (rd_ptr_q),
        .doutb  (rd0_data_c),
        .addrc  (rd_ptr1_c),
        .doutc  (rd1_data_c)
    );

endmodule

// File: tb/tb_common_dffram_fifo_1w2r.sv
// Randomized scoreboard bench for common_dffram_fifo_1w2r (either bypass build).
module tb_common_dffram_fifo_1w2r;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          flush = 1'b0;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [DW-1:0] push_data = '0;
    logic          pop0_valid;
    logic          pop0_ready = 1'b0;
    logic [DW-1:0] pop0_data;
    logic          pop1_valid;
    logic          pop1_ready = 1'b0;
    logic [DW-1:0] pop1_data;
    logic [AW:0]   count;
    logic          empty;
    logic          full;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    logic [DW-1:0] exp_q[$];

    common_dffram_fifo_1w2r #(
        .FIFO_DATA_WIDTH (DW),
        .FIFO_ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop0_valid (pop0_valid),
        .pop0_ready (pop0_ready),
        .pop0_data  (pop0_data),
        .pop1_valid (pop1_valid),
        .pop1_ready (pop1_ready),
        .pop1_data  (pop1_data),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor/scoreboard: compare this cycle's outputs, then retire/enqueue per the rules.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            int  n;
            bit  e_pr, e_p0v, e_p1v, byp, pf, p0f, p1f;
            n     = exp_q.size();
            e_pr  = (n < DEPTH) && !flush;
            byp   = 1'b0;
`ifdef COMMON_DFFRAM_FIFO_1W2R_BYPASS_EN
            byp   = (n == 0) && push_valid && !flush;
`endif
            e_p0v = ((n >= 1) && !flush) || byp;
            e_p1v = (n >= 2) && !flush;
            check("push_ready", DW'(push_ready), DW'(e_pr));
            check("pop0_valid", DW'(pop0_valid), DW'(e_p0v));
            check("pop1_valid", DW'(pop1_valid), DW'(e_p1v));
            check("count", DW'(count), DW'(n));
            check("empty", DW'(empty), DW'(n == 0));
            check("full", DW'(full), DW'(n == DEPTH));
            if (e_p0v) check("pop0_data", pop0_data, byp ? push_data : exp_q[0]);
            if (e_p1v) check("pop1_data", pop1_data, exp_q[1]);

            pf  = push_valid && e_pr;
            p0f = e_p0v && pop0_ready;
            p1f = e_p1v && pop1_ready && p0f;
            if (flush) begin
                exp_q.delete();
            end else if (!(byp && p0f)) begin
                if (p0f) void'(exp_q.pop_front());
                if (p1f) void'(exp_q.pop_front());
                if (pf) exp_q.push_back(push_data);
            end
        end
    end

    task automatic cyc(input bit pv, input logic [DW-1:0] pd, input bit p0r, input bit p1r, input bit fl);
        push_valid = pv;
        push_data  = pd;
        pop0_ready = p0r;
        pop1_ready = p1r;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_push_ready", DW'(push_ready), DW'(1));
        check("rst_pop0_valid", DW'(pop0_valid), DW'(0));
        check("rst_pop1_valid", DW'(pop1_valid), DW'(0));
        check("rst_count", DW'(count), DW'(0));
        check("rst_empty", DW'(empty), DW'(1));
        check("rst_full", DW'(full), DW'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        resetn = 1'b1;

        // Fill to full, then a ninth push held against full.
        for (int i = 0; i < 8; i++) cyc(1'b1, DW'(32'h10 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, DW'(32'h18), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, DW'(32'h19), 1'b0, 1'b0, 1'b0);

        // Dual pop drains in pairs.
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Wrap: 1 push/cycle against 2 pops/cycle, with refills.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, $urandom, 1'b1, (i % 3) != 0, 1'b0);
            cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        end

        // Illegal pop1-only at count 3.
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Flush with push and pop0_ready at count 5.
        cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, DW'(32'hDEAD), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Push 0xAB into an empty FIFO with pop0_ready (bypass or not).
        cyc(1'b1, DW'(32'hAB), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // Randomized traffic with varying push pressure and rare flushes.
        for (int seg = 0; seg < 8; seg++) begin
            int unsigned push_pct;
            push_pct = (seg % 2 == 0) ? 85 : 30;
            for (int i = 0; i < 60; i++) begin
                cyc($urandom_range(99) < push_pct, $urandom, $urandom_range(1),
                    $urandom_range(1), $urandom_range(63) == 0);
            end
        end

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        push_valid = 1'b0;
        pop0_ready = 1'b0;
        pop1_ready = 1'b0;
        flush      = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;

        for (int i = 0; i < 40; i++) begin
            cyc($urandom_range(1), $urandom, $urandom_range(1), $urandom_range(1), 1'b0);
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/common_dffram_fifo_1w2r.md
# common_dffram_fifo_1w2r

In-order FIFO controller that sequences a DFF RAM with one write port and two read ports. It accepts at most one push per cycle and retires up to two oldest entries per cycle. It serves as a dual-issue instruction/uop buffer, or anywhere a producer runs at 1/cycle and a consumer drains 2/cycle. The controller owns the write and read pointers and the occupancy count, and drives the RAM's write port and both read-address ports.

## Interface
- `FIFO_DATA_WIDTH`, default 32: entry width in bits.
- `FIFO_ADDR_WIDTH`, default 3: pointer width. Depth `FIFO_DEPTH = 1 << FIFO_ADDR_WIDTH`.
- `clk` in 1: the single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear of all entries.
- `push_valid` in 1: producer offers an entry.
- `push_ready` out 1: the FIFO can accept an entry.
- `push_data` in `FIFO_DATA_WIDTH`: entry payload.
- `pop0_valid` out 1: the oldest entry is available.
- `pop0_ready` in 1: consumer takes the oldest entry.
- `pop0_data` out `FIFO_DATA_WIDTH`: oldest entry.
- `pop1_valid` out 1: the second-oldest entry is available.
- `pop1_ready` in 1: consumer takes the second-oldest entry.
- `pop1_data` out `FIFO_DATA_WIDTH`: second-oldest entry.
- `count` out `FIFO_ADDR_WIDTH+1`: current occupancy.
- `empty` out 1: `count == 0`.
- `full` out 1: `count == FIFO_DEPTH`.

## Operation
- **State:** `wr_ptr` and `rd_ptr`, each `FIFO_ADDR_WIDTH` bits, wrapping modulo `FIFO_DEPTH` with natural overflow; `count`, `FIFO_ADDR_WIDTH+1` bits.
- **Reset values:** `wr_ptr = rd_ptr = count = 0`, `empty = 1`, `full = 0`, `push_ready = 1`, `pop0_valid = pop1_valid = 0`. Storage contents are not reset and are undefined until written.
- **Push fire:** `push_valid & push_ready`, with `push_ready = !full & !flush`. The entry is written at `wr_ptr` with all bit-enables set, and `wr_ptr` increments.
- **Pop validity:** `pop0_valid = (count >= 1) & !flush`; `pop1_valid = (count >= 2) & !flush`.
- **Pop fire:**
  - `pop0_fire = pop0_valid & pop0_ready`.
  - `pop1_fire = pop1_valid & pop1_ready & pop0_fire`. Popping slot 1 without slot 0 is never allowed; `pop1_ready` alone is ignored.
  - `rd_ptr` advances by `pop0_fire + pop1_fire`.
- **Read addressing:** read address B = `rd_ptr`, read address C = `rd_ptr + 1` (wrapping). `pop0_data` is driven from B and `pop1_data` from C, combinationally.
- **Count update:** `count_next = count + push_fire - pop0_fire - pop1_fire`, computed at `FIFO_ADDR_WIDTH+1` bits. It can never underflow or overflow by construction.
- **Flush:** for one cycle, zeroes both pointers and `count` at the next edge. Flush has priority over a push or pop in the same cycle; neither fires.
- **Full and empty boundaries:**
  - Push is refused when full, even if a pop fires in the same cycle. `push_ready` does not depend on the pop inputs.
  - Popping while empty is impossible because `pop0_valid` is 0.
- **Same-cycle write and read of one slot:** when a write targets the slot being read, the read returns the old contents. This is harmless because the written slot is never valid at that point.

## Timing
- Read latency is 0 cycles: pop data is valid in the same cycle as `pop*_valid`.
- A pushed entry becomes poppable one cycle after the push fires, unless bypass is enabled (see Configuration).
- Pointers, `count`, `empty` and `full` update on the rising `clk` edge following the fire.
- Asserting `resetn` low mid-operation clears all state immediately, asynchronously. Release is synchronous to `clk`.
- No combinational path exists from `pop*_ready` to `push_ready`.

## Configuration
- **Macro:** `COMMON_DFFRAM_FIFO_1W2R_BYPASS_EN`.
- **Defined:**
  - When `count == 0`, `push_valid` is 1 and `flush` is 0, `pop0_valid = 1` and `pop0_data = push_data`.
  - If `pop0_fire` in that cycle, the entry is consumed without being written, and pointers and `count` are unchanged.
  - `pop1` is never bypassed.
  - This creates a combinational path from `push_valid`/`push_data` to `pop0_valid`/`pop0_data`.
- **Undefined:** no bypass; an empty FIFO shows `pop0_valid = 0` regardless of the push inputs.

## Structure
- **Shared package `common_dffram_fifo_pkg`:**
  - Localparam helper functions for depth (`1 << addr_width`) and count width (`addr_width + 1`).
  - An enum for pop count (`POP_NONE`, `POP_ONE`, `POP_TWO`) used by the next-state logic.
- **Sub-module:** exactly one storage instance, `common_dffram_3a1we2r`, sized `FIFO_DATA_WIDTH` × `FIFO_ADDR_WIDTH`.
  - Port A is driven by the controller: `ena = push_fire` (gated off by bypass consumption), `wea` all ones, `addra = wr_ptr`, `dina = push_data`.
  - The storage reset is held inactive.
- All pointer and count logic lives in this module.

## Test plan
- **Reset and fill to full:** after reset, push 8 entries 0x10..0x17 with `FIFO_ADDR_WIDTH = 3` → `count` goes 1..8, then `full = 1` and `push_ready = 0`. A ninth push with `push_valid` held does not fire.
- **Dual pop:** from full, hold `pop0_ready = pop1_ready = 1` for 4 cycles → pairs (0x10,0x11), (0x12,0x13), … retire in order, then `empty = 1`.
- **Wrap and simultaneous events:**
  - Interleave 1 push/cycle with 2 pops/cycle across 20 cycles so both pointers wrap past 7.
  - Data order must be preserved and `count` must match the model every cycle.
  - Cover push+pop2 at `count = 2` → `count = 1`.
- **Illegal pop pattern:** with `count = 3`, drive `pop1_ready = 1`, `pop0_ready = 0` → nothing retires and `count` stays 3.
- **Flush and reset priority:**
  - Flush asserted together with a push and `pop0_ready` at `count = 5` → next cycle `count = 0`, and the push is not stored.
  - `resetn` pulsed low mid-stream → outputs take their reset values immediately.
- **Bypass build:** when empty, push 0xAB with `pop0_ready = 1` → `pop0_data = 0xAB` in the same cycle and `count` stays 0. In the non-bypass build the same stimulus gives `pop0_valid = 0` and `count = 1`.
